// File: rtl/fifo_wr_arb_pkg.sv
// Shared definitions for the fifo_wr_arb round-robin FIFO write arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } arb_state_e;

  localparam int FIFO_DEPTH = 8;
  localparam int ERR_W_DEF  = 8;

endpackage

// File: rtl/fifo_arb_rr.sv
// Combinational 2-way round-robin picker: a lone requester always wins, a tie goes to !rr_last.
module fifo_arb_rr (
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~rr_last : req1;

endmodule

// File: rtl/fifo_wr_arb.sv
// Two-producer write arbiter for an 8-entry FIFO, retrying rejected writes in order.
// Define FIFO_WR_ARB_ERR_CNT_EN to add per-requester saturating rejection counters.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int DATA_W = 32
`ifdef FIFO_WR_ARB_ERR_CNT_EN
  , parameter int ERR_W = ERR_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              owner,
  output logic              busy,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  input  logic              fifo_wr_ack,
  input  logic              fifo_wr_err,
  input  logic              fifo_full
`ifdef FIFO_WR_ARB_ERR_CNT_EN
  ,
  output logic [ERR_W-1:0]  err_cnt0,
  output logic [ERR_W-1:0]  err_cnt1
`endif
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              retry_q, retry_d;
  logic              rr_last_q, rr_last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pick_valid;
  logic              pick_winner;

  fifo_arb_rr u_rr (
    .req0    (req0),
    .req1    (req1),
    .rr_last (rr_last_q),
    .valid   (pick_valid),
    .winner  (pick_winner)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    retry_d   = retry_q;
    rr_last_d = rr_last_q;
    data_d    = data_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_winner;
          data_d  = pick_winner ? din1 : din0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Ack beats err; a rejected word keeps its owner and data until the FIFO drains.
        if (fifo_wr_ack) begin
          state_d   = DONE;
          rr_last_d = owner_q;
          retry_d   = 1'b0;
        end else if (fifo_wr_err) begin
          retry_d = 1'b1;
        end else if (retry_q && !fifo_full) begin
          state_d = ISSUE;
          retry_d = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      retry_q   <= 1'b0;
      rr_last_q <= 1'b1;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      retry_q   <= retry_d;
      rr_last_q <= rr_last_d;
      data_q    <= data_d;
    end
  end

  assign fifo_wr_en = (state_q == ISSUE);
  assign fifo_din   = data_q;
  assign busy       = (state_q != IDLE);
  assign owner      = owner_q;
  assign gnt0       = (state_q == DONE) && !owner_q;
  assign gnt1       = (state_q == DONE) &&  owner_q;

`ifdef FIFO_WR_ARB_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt0_q, err_cnt0_d;
  logic [ERR_W-1:0] err_cnt1_q, err_cnt1_d;
  logic             err_inc;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    err_inc    = (state_q == WAIT) && fifo_wr_err && !fifo_wr_ack;
    err_cnt0_d = (err_inc && !owner_q) ? sat_inc(err_cnt0_q) : err_cnt0_q;
    err_cnt1_d = (err_inc &&  owner_q) ? sat_inc(err_cnt1_q) : err_cnt1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_cnt0_q <= '0;
      err_cnt1_q <= '0;
    end else begin
      err_cnt0_q <= err_cnt0_d;
      err_cnt1_q <= err_cnt1_d;
    end
  end

  assign err_cnt0 = err_cnt0_q;
  assign err_cnt1 = err_cnt1_q;
`endif

endmodule
